// File: rtl/sdram_pkg.sv
// sdram_pkg -- types and constants shared by the SDRAM controller blocks.
//   * arb_state_e : refresh/CPU arbiter FSM states
//   * debt_t      : owed-refresh counter type (DEBT_W bits, MAX_DEBT <= 15)
//   * DEF_*       : default refresh timing (100 MHz clock, 64 ms / 8192 rows)
//   * sdram_cmd_e : {cs_n, ras_n, cas_n, we_n} command encodings
package sdram_pkg;

    localparam int DEBT_W               = 4;
    localparam int DEF_REFRESH_INTERVAL = 780;
    localparam int DEF_MAX_DEBT         = 8;
    localparam int DEF_URGENT_DEBT      = 6;

    typedef logic [DEBT_W-1:0] debt_t;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_IDLE      = 2'd1,
        ST_CPU       = 2'd2,
        ST_REFRESH   = 2'd3
    } arb_state_e;

    typedef enum logic [3:0] {
        CMD_LOAD_MODE    = 4'b0000,
        CMD_AUTO_REFRESH = 4'b0001,
        CMD_PRECHARGE    = 4'b0010,
        CMD_ACTIVE       = 4'b0011,
        CMD_WRITE        = 4'b0100,
        CMD_READ         = 4'b0101,
        CMD_NOP          = 4'b0111,
        CMD_INHIBIT      = 4'b1111
    } sdram_cmd_e;

endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer -- periodic refresh tick generator.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   run   : high once SDRAM init is complete; while low the counter is held
//           at its reload value so the first tick is a full interval away
//   tick  : one-cycle pulse every REFRESH_INTERVAL cycles while run is high
module sdram_refresh_timer
    import sdram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = run && (cnt_q == '0);
        cnt_d = cnt_q - 1'b1;
        if (!run || tick) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sdram_refresh_arbiter.sv
// sdram_refresh_arbiter -- shares the SDRAM command bus between the CPU and
// the periodic AUTO REFRESH, tracking how many refreshes are owed.
//   clk, RESETn  : clock, asynchronous active-low reset
//   init_done    : SDRAM init sequence finished (level)
//   cpu_req      : CPU access pending (level)
//   cpu_done     : granted CPU access finished (pulse, ignored outside CPU)
//   ref_ack      : refresh issued and tRFC elapsed (pulse, ignored outside REFRESH)
//   cpu_grant    : CPU owns the command bus (registered)
//   ref_req      : command engine must issue AUTO REFRESH (registered)
//   ref_debt     : owed refreshes, saturating at MAX_DEBT
//   ref_urgent   : ref_debt >= URGENT_DEBT
//   ref_overrun  : sticky, a tick arrived with debt already at MAX_DEBT
module sdram_refresh_arbiter
    import sdram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int MAX_DEBT         = DEF_MAX_DEBT,
    parameter int URGENT_DEBT      = DEF_URGENT_DEBT
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic              init_done,
    input  logic              cpu_req,
    input  logic              cpu_done,
    input  logic              ref_ack,
    output logic              cpu_grant,
    output logic              ref_req,
    output logic [DEBT_W-1:0] ref_debt,
    output logic              ref_urgent,
    output logic              ref_overrun
);

    localparam debt_t MAX_D = DEBT_W'(MAX_DEBT);
    localparam debt_t URG_D = DEBT_W'(URGENT_DEBT);

    arb_state_e state_q, state_d;
    logic       cpu_grant_q, cpu_grant_d;
    logic       ref_req_q, ref_req_d;
    debt_t      debt_q, debt_d;
    logic       overrun_q, overrun_d;
    logic       tick;
    logic       ack_eff;

    sdram_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_timer (
        .clk   (clk),
        .rst_n (RESETn),
        .run   (state_q != ST_WAIT_INIT),
        .tick  (tick)
    );

    // Debt bookkeeping. A tick and an ack in the same cycle cancel out; a
    // tick at saturation is lost and flagged as an overrun.
    always_comb begin
        ack_eff   = (state_q == ST_REFRESH) && ref_ack;
        debt_d    = debt_q;
        overrun_d = overrun_q;
        if (tick && (debt_q == MAX_D)) begin
            overrun_d = 1'b1;
        end
        if (tick && !ack_eff) begin
            if (debt_q != MAX_D) debt_d = debt_q + 1'b1;
        end else if (!tick && ack_eff) begin
            if (debt_q != '0) debt_d = debt_q - 1'b1;
        end
    end

    // Arbitration. Urgency is only looked at in IDLE, so a running CPU
    // access always completes before an urgent refresh takes the bus.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT_INIT: if (init_done) state_d = ST_IDLE;
            ST_IDLE: begin
                if (debt_q >= URG_D)     state_d = ST_REFRESH;
                else if (cpu_req)        state_d = ST_CPU;
                else if (debt_q != '0)   state_d = ST_REFRESH;
            end
            ST_CPU:       if (cpu_done) state_d = ST_IDLE;
            ST_REFRESH:   if (ref_ack)  state_d = ST_IDLE;
            default:      state_d = ST_WAIT_INIT;
        endcase
        // Outputs are decoded from the next state so they are registered
        // alongside it; grant and refresh request are mutually exclusive.
        cpu_grant_d = (state_d == ST_CPU);
        ref_req_d   = (state_d == ST_REFRESH);
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= ST_WAIT_INIT;
            cpu_grant_q <= 1'b0;
            ref_req_q   <= 1'b0;
            debt_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_grant_q <= cpu_grant_d;
            ref_req_q   <= ref_req_d;
            debt_q      <= debt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign cpu_grant   = cpu_grant_q;
    assign ref_req     = ref_req_q;
    assign ref_debt    = debt_q;
    assign ref_urgent  = (debt_q >= URG_D);
    assign ref_overrun = overrun_q;

endmodule

// File: tb/tb_sdram_refresh_arbiter.sv
// Self-checking bench for sdram_refresh_arbiter (interval 16, max 8, urgent 6).
module tb_sdram_refresh_arbiter;

    localparam int INT  = 16;
    localparam int MAXD = 8;
    localparam int URG  = 6;

    logic       clk = 1'b0;
    logic       RESETn;
    logic       init_done, cpu_req, cpu_done, ref_ack;
    logic       cpu_grant, ref_req, ref_urgent, ref_overrun;
    logic [3:0] ref_debt;

    int checks = 0;
    int errors = 0;

    sdram_refresh_arbiter #(
        .REFRESH_INTERVAL (INT),
        .MAX_DEBT         (MAXD),
        .URGENT_DEBT      (URG)
    ) dut (
        .clk         (clk),
        .RESETn      (RESETn),
        .init_done   (init_done),
        .cpu_req     (cpu_req),
        .cpu_done    (cpu_done),
        .ref_ack     (ref_ack),
        .cpu_grant   (cpu_grant),
        .ref_req     (ref_req),
        .ref_debt    (ref_debt),
        .ref_urgent  (ref_urgent),
        .ref_overrun (ref_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_n counts clock edges since init was seen; a refresh falls due on
    // every INT-th edge. m_mode: 0 idle, 1 cpu owns bus, 2 refreshing.
    bit m_inited;
    int m_n, m_debt, m_mode;
    bit m_ovr;

    always @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            m_inited = 0; m_n = 0; m_debt = 0; m_mode = 0; m_ovr = 0;
        end else begin
            bit tk, ak;
            int od;
            od = m_debt;
            tk = m_inited && (((m_n + 1) % INT) == 0);
            ak = m_inited && (m_mode == 2) && ref_ack;
            if (tk && od == MAXD) m_ovr = 1;
            m_debt = od + (tk ? 1 : 0) - (ak ? 1 : 0);
            if (m_debt > MAXD) m_debt = MAXD;
            if (m_debt < 0) m_debt = 0;
            if (!m_inited) begin
                if (init_done) begin m_inited = 1; m_n = 0; m_mode = 0; end
            end else begin
                m_n++;
                case (m_mode)
                    0: if (od >= URG) m_mode = 2;
                       else if (cpu_req) m_mode = 1;
                       else if (od > 0) m_mode = 2;
                    1: if (cpu_done) m_mode = 0;
                    default: if (ref_ack) m_mode = 0;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (RESETn) begin
            chk("cpu_grant", cpu_grant, (m_inited && m_mode == 1) ? 1 : 0);
            chk("ref_req", ref_req, (m_inited && m_mode == 2) ? 1 : 0);
            chk("ref_debt", ref_debt, m_debt);
            chk("ref_urgent", ref_urgent, (m_debt >= URG) ? 1 : 0);
            chk("ref_overrun", ref_overrun, m_ovr ? 1 : 0);
            chk("exclusive", (cpu_grant && ref_req) ? 1 : 0, 0);
        end
    end

    task automatic step();
        @(negedge clk);
        cpu_done = 0;
        ref_ack  = 0;
    endtask

    // Ack pending refreshes until debt is clear and the bus is idle.
    task automatic drain();
        int n;
        n = 0;
        while ((ref_debt != 0 || ref_req) && n < 400) begin
            step();
            if (ref_req) ref_ack = 1;
            n++;
        end
        step();
        if (n >= 400) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int gcnt, n;
        bit saw_urg, pend, ok, bad;

        RESETn = 0; init_done = 0; cpu_req = 0; cpu_done = 0; ref_ack = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_grant", cpu_grant, 0);
        chk("rst_req", ref_req, 0);
        chk("rst_debt", ref_debt, 0);
        chk("rst_overrun", ref_overrun, 0);
        RESETn = 1;

        // No ticks before init.
        repeat (100) step();
        chk("preinit_debt", ref_debt, 0);
        chk("preinit_req", ref_req, 0);
        init_done = 1;
        repeat (16) step();
        chk("tick15_debt", ref_debt, 0);
        step();
        chk("tick16_debt", ref_debt, 1);
        chk("tick16_req", ref_req, 0);
        step();
        chk("first_req", ref_req, 1);
        ref_ack = 1;
        step();
        chk("ack_debt", ref_debt, 0);
        chk("ack_req", ref_req, 0);

        // Long CPU accesses: debt becomes urgent mid-access, refresh wins next.
        cpu_req = 1; gcnt = 0; saw_urg = 0; pend = 0; ok = 0; bad = 0; n = 0;
        while (!ok && !bad && n < 1000) begin
            step();
            n++;
            if (pend) begin
                if (ref_req) ok = 1;
                else if (cpu_grant) bad = 1;
            end
            if (cpu_grant) begin
                if (ref_debt >= URG) saw_urg = 1;
                gcnt++;
                if (gcnt == 40) begin
                    cpu_done = 1;
                    gcnt = 0;
                    if (ref_debt >= URG) pend = 1;
                end
            end
            if (ref_req) ref_ack = 1;
        end
        chk("urgent_in_cpu", saw_urg, 1);
        chk("refresh_before_grant", ok, 1);
        cpu_req = 0;
        drain();

        // Tick and ack in the same cycle at debt 3.
        ok = 0; n = 0;
        while (!ok && n < 200) begin
            step();
            n++;
            if (ref_debt == 3 && ref_req && (((m_n + 1) % INT) == 0)) begin
                ref_ack = 1;
                ok = 1;
            end
        end
        chk("align_found", ok, 1);
        step();
        chk("tickack_debt", ref_debt, 3);
        chk("tickack_idle", ref_req, 0);
        step();
        chk("tickack_rereq", ref_req, 1);

        // Saturation and sticky overrun.
        repeat (INT * 10) step();
        chk("sat_debt", ref_debt, MAXD);
        chk("sat_overrun", ref_overrun, 1);
        chk("sat_urgent", ref_urgent, 1);
        n = 0;
        for (int a = 0; a < 4 && n < 100; ) begin
            step();
            n++;
            if (ref_req) begin ref_ack = 1; a++; end
        end
        step();
        chk("overrun_sticky", ref_overrun, 1);

        // Reset mid-refresh.
        n = 0;
        while (!ref_req && n < 100) begin step(); n++; end
        chk("in_refresh", ref_req, 1);
        RESETn = 0;
        #1;
        chk("midrst_req", ref_req, 0);
        chk("midrst_debt", ref_debt, 0);
        chk("midrst_overrun", ref_overrun, 0);
        init_done = 0; cpu_req = 1;
        step();
        RESETn = 1;
        repeat (30) step();
        chk("noinit_grant", cpu_grant, 0);
        init_done = 1;
        step();
        chk("init_grant0", cpu_grant, 0);
        step();
        chk("init_grant1", cpu_grant, 1);
        cpu_done = 1;
        cpu_req = 0;
        step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom_range(7) == 0) cpu_req = ~cpu_req;
            if (cpu_grant ? ($urandom_range(9) == 0) : ($urandom_range(49) == 0)) cpu_done = 1;
            if (ref_req ? ($urandom_range(3) == 0) : ($urandom_range(39) == 0)) ref_ack = 1;
            if ($urandom_range(999) == 0) begin
                RESETn = 0;
                init_done = 0;
                step();
                step();
                RESETn = 1;
                repeat ($urandom_range(5)) step();
                init_done = 1;
            end
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_refresh_arbiter.md
SDRAM_REFRESH_ARBITER -- requirements
Module: sdram_refresh_arbiter

Interface
REQ-001 Parameter REFRESH_INTERVAL, default 780, clk cycles per refresh tick (7.8 us at 100 MHz).
REQ-002 Parameter MAX_DEBT, default 8, maximum owed refreshes (range 2..15).
REQ-003 Parameter URGENT_DEBT, default 6, debt level at which refresh beats CPU.
REQ-004 Port clk, input, 1, single clock; all state on rising edge.
REQ-005 Port RESETn, input, 1, reset, asynchronous, active-low.
REQ-006 Port init_done, input, 1, level, SDRAM init sequence complete.
REQ-007 Port cpu_req, input, 1, level, CPU access pending.
REQ-008 Port cpu_done, input, 1, one-cycle pulse, granted CPU access finished.
REQ-009 Port ref_ack, input, 1, one-cycle pulse, AUTO REFRESH issued plus tRFC elapsed.
REQ-010 Port cpu_grant, output, 1, CPU owns SDRAM command bus.
REQ-011 Port ref_req, output, 1, command engine shall issue AUTO REFRESH.
REQ-012 Port ref_debt, output, 4, current owed-refresh count.
REQ-013 Port ref_urgent, output, 1, ref_debt >= URGENT_DEBT.
REQ-014 Port ref_overrun, output, 1, sticky, tick arrived while debt == MAX_DEBT.

Function
REQ-015 FSM states SHALL be WAIT_INIT, IDLE, CPU, REFRESH; all outputs registered.
REQ-016 Tick counter SHALL load REFRESH_INTERVAL-1 and count down only after init_done is seen; tick = counter at 0, then reload.
REQ-017 In WAIT_INIT: no grants, no ticks; init_done high -> IDLE next cycle, counter loaded.
REQ-018 Each tick SHALL increment ref_debt, saturating at MAX_DEBT.
REQ-019 A tick at MAX_DEBT SHALL set ref_overrun; it is cleared only by reset.
REQ-020 ref_ack in REFRESH SHALL decrement ref_debt; tick and ack in the same cycle SHALL leave ref_debt unchanged.
REQ-021 ref_ack outside REFRESH SHALL be ignored.
REQ-022 IDLE priority, evaluated each cycle: 1) ref_debt >= URGENT_DEBT -> REFRESH; 2) cpu_req -> CPU; 3) ref_debt > 0 -> REFRESH; 4) stay.
REQ-023 cpu_grant SHALL rise the cycle after the IDLE decision (1-cycle latency) and hold until cpu_done; cpu_done -> IDLE, cpu_grant low next cycle.
REQ-024 A CPU access SHALL NOT be pre-empted; urgency is evaluated only in IDLE.
REQ-025 ref_req SHALL be high throughout REFRESH; ref_ack -> IDLE, ref_req low next cycle.
REQ-026 cpu_grant and ref_req SHALL never be high together.
REQ-027 ref_urgent SHALL be combinational on the registered ref_debt.
REQ-028 cpu_done outside CPU SHALL be ignored.

Reset
REQ-029 RESETn low SHALL force immediately: state WAIT_INIT, counter REFRESH_INTERVAL-1, ref_debt 0, cpu_grant 0, ref_req 0, ref_overrun 0.
REQ-030 Reset during CPU or REFRESH SHALL abandon the operation; the next grant requires init_done again.

Structure
REQ-031 State enum, debt width and default timing constants SHALL live in the shared package sdram_pkg, alongside the SDRAM command encodings.
REQ-032 The tick counter SHALL be a sub-module, sdram_refresh_timer (outputs a one-cycle tick); the FSM and debt logic stay in the top module.

Verification (REFRESH_INTERVAL=16, MAX_DEBT=8, URGENT_DEBT=6)
REQ-033 Hold init_done=0 for 100 cycles -> no tick, ref_debt=0; raise init_done -> first tick 16 cycles later, ref_debt=1, ref_req high the next cycle.
REQ-034 cpu_req held with cpu_done every 40 cycles -> debt reaches 6 during a CPU access; after cpu_done, ref_req rises before the next cpu_grant.
REQ-035 Tick and ref_ack in the same cycle at ref_debt=3 -> ref_debt stays 3, FSM returns to IDLE.
REQ-036 No ref_ack for 9 ticks with cpu_req=0 -> ref_debt saturates at 8, ref_overrun=1 and stays 1 after later acks.
REQ-037 RESETn pulsed low mid-REFRESH -> ref_req=0 the same cycle, ref_debt=0, state WAIT_INIT.
REQ-038 Assertion on every cycle: !(cpu_grant && ref_req); cpu_req to cpu_grant latency is 1 cycle when ref_debt=0.
